// File: rtl/cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache, one word per line; CACHE_WRITE_THROUGH_EN selects write-through/no-allocate.
// Latency: read hit responds 1 cycle after accept; misses are bounded by memory ready/response timing.
// Backpressure: rx_req_ready drops in every non-IDLE state; tx_req_* held stable while tx_req_valid && !tx_req_ready.
module cache_ctrl #(
    parameter int ADDR_WIDTH  = 6,
    parameter int DATA_WIDTH  = 8,
    parameter int INDEX_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_req_valid,
    output logic                  rx_req_ready,
    input  logic                  rx_req_write,
    input  logic [ADDR_WIDTH-1:0] rx_req_addr,
    input  logic [DATA_WIDTH-1:0] rx_req_data,
    output logic                  rx_rsp_valid,
    output logic [DATA_WIDTH-1:0] rx_rsp_data,
    output logic                  tx_req_valid,
    input  logic                  tx_req_ready,
    output logic                  tx_req_write,
    output logic [ADDR_WIDTH-1:0] tx_req_addr,
    output logic [DATA_WIDTH-1:0] tx_req_data,
    input  logic                  tx_rsp_valid,
    input  logic [DATA_WIDTH-1:0] tx_rsp_data
);

    localparam int LINES     = 1 << INDEX_WIDTH;
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITEBACK = 3'd1,
        FILL_REQ  = 3'd2,
        FILL_WAIT = 3'd3,
        WRITE_FWD = 3'd4
    } state_t;

    state_t                  state, state_nxt;
    logic                    ready_q;
    logic                    lat_write;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_data;

    logic [DATA_WIDTH-1:0]   line_dat [LINES];
    logic [TAG_WIDTH-1:0]    line_tag [LINES];
    logic [LINES-1:0]        line_vld;
    logic [LINES-1:0]        line_dirty;

    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [DATA_WIDTH-1:0]   cur_data;
    logic [INDEX_WIDTH-1:0]  cur_idx;
    logic [TAG_WIDTH-1:0]    cur_tag;
    logic [INDEX_WIDTH-1:0]  lat_idx;
    logic                    accept;
    logic                    hit;
    logic                    fill_done;

    // Ready only after reset has been released for a cycle, and only when idle.
    assign rx_req_ready = ready_q && (state == IDLE);
    assign accept       = rx_req_valid && rx_req_ready;
    assign fill_done    = (state == FILL_WAIT) && tx_rsp_valid;
    assign lat_idx      = lat_addr[INDEX_WIDTH-1:0];

    // The working request is the incoming one while idle, the latched one otherwise.
    always_comb begin
        cur_addr = (state == IDLE) ? rx_req_addr : lat_addr;
        cur_data = (state == IDLE) ? rx_req_data : lat_data;
        cur_idx  = cur_addr[INDEX_WIDTH-1:0];
        cur_tag  = cur_addr[ADDR_WIDTH-1:INDEX_WIDTH];
        hit      = line_vld[cur_idx] && (line_tag[cur_idx] == cur_tag);
    end

    // Next-state logic for the miss / forward sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef CACHE_WRITE_THROUGH_EN
                    if (rx_req_write)
                        state_nxt = WRITE_FWD;
                    else if (!hit)
                        state_nxt = FILL_REQ;
`else
                    if (!hit)
                        state_nxt = (line_vld[cur_idx] && line_dirty[cur_idx]) ? WRITEBACK : FILL_REQ;
`endif
                end
            end
            WRITEBACK: if (tx_req_ready) state_nxt = FILL_REQ;
            FILL_REQ:  if (tx_req_ready) state_nxt = FILL_WAIT;
            FILL_WAIT: if (tx_rsp_valid) state_nxt = IDLE;
            WRITE_FWD: if (tx_req_ready) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // State, line status bits, latched request, responses and the registered memory request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            ready_q      <= 1'b0;
            line_vld     <= '0;
            line_dirty   <= '0;
            lat_write    <= 1'b0;
            lat_addr     <= '0;
            lat_data     <= '0;
            rx_rsp_valid <= 1'b0;
            rx_rsp_data  <= '0;
            tx_req_valid <= 1'b0;
            tx_req_write <= 1'b0;
            tx_req_addr  <= '0;
            tx_req_data  <= '0;
        end else begin
            state        <= state_nxt;
            ready_q      <= 1'b1;
            rx_rsp_valid <= 1'b0;
            if (accept) begin
                lat_write <= rx_req_write;
                lat_addr  <= rx_req_addr;
                lat_data  <= rx_req_data;
            end
            if (accept && hit && !rx_req_write) begin
                rx_rsp_valid <= 1'b1;
                rx_rsp_data  <= line_dat[cur_idx];
            end
`ifndef CACHE_WRITE_THROUGH_EN
            if (accept && hit && rx_req_write)
                line_dirty[cur_idx] <= 1'b1;
`endif
            if (fill_done) begin
                line_vld[lat_idx] <= 1'b1;
`ifdef CACHE_WRITE_THROUGH_EN
                line_dirty[lat_idx] <= 1'b0;
`else
                line_dirty[lat_idx] <= lat_write;
`endif
                if (!lat_write) begin
                    rx_rsp_valid <= 1'b1;
                    rx_rsp_data  <= tx_rsp_data;
                end
            end
            // Request fields are recomputed from stable sources every cycle, so they hold while stalled.
            tx_req_valid <= (state_nxt == WRITEBACK) || (state_nxt == FILL_REQ) || (state_nxt == WRITE_FWD);
            case (state_nxt)
                WRITEBACK: begin
                    tx_req_write <= 1'b1;
                    tx_req_addr  <= {line_tag[cur_idx], cur_idx};
                    tx_req_data  <= line_dat[cur_idx];
                end
                FILL_REQ: begin
                    tx_req_write <= 1'b0;
                    tx_req_addr  <= cur_addr;
                end
                WRITE_FWD: begin
                    tx_req_write <= 1'b1;
                    tx_req_addr  <= cur_addr;
                    tx_req_data  <= cur_data;
                end
                default: ;
            endcase
        end
    end

    // Line data and tags: updated by write hits and by line installs.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (accept && hit && rx_req_write)
                line_dat[cur_idx] <= rx_req_data;
            if (fill_done) begin
                line_tag[lat_idx] <= lat_addr[ADDR_WIDTH-1:INDEX_WIDTH];
                line_dat[lat_idx] <= lat_write ? lat_data : tx_rsp_data;
            end
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;

`ifdef CACHE_WRITE_THROUGH_EN
    localparam bit WT = 1'b1;
`else
    localparam bit WT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_req_valid = 1'b0;
    logic       rx_req_ready;
    logic       rx_req_write = 1'b0;
    logic [5:0] rx_req_addr = '0;
    logic [7:0] rx_req_data = '0;
    logic       rx_rsp_valid;
    logic [7:0] rx_rsp_data;
    logic       tx_req_valid;
    logic       tx_req_ready = 1'b0;
    logic       tx_req_write;
    logic [5:0] tx_req_addr;
    logic [7:0] tx_req_data;
    logic       tx_rsp_valid = 1'b0;
    logic [7:0] tx_rsp_data = '0;

    always #5 clk = ~clk;

    cache_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .INDEX_WIDTH(3)) dut (
        .clk(clk), .rst(rst),
        .rx_req_valid(rx_req_valid), .rx_req_ready(rx_req_ready), .rx_req_write(rx_req_write),
        .rx_req_addr(rx_req_addr), .rx_req_data(rx_req_data),
        .rx_rsp_valid(rx_rsp_valid), .rx_rsp_data(rx_rsp_data),
        .tx_req_valid(tx_req_valid), .tx_req_ready(tx_req_ready), .tx_req_write(tx_req_write),
        .tx_req_addr(tx_req_addr), .tx_req_data(tx_req_data),
        .tx_rsp_valid(tx_rsp_valid), .tx_rsp_data(tx_rsp_data)
    );

    // Knobs written only by the stimulus process.
    int rsp_delay = 2;
    int stall_cycles = 0;
    int stall_gen = 0;

    // Memory model state, written only by the responder.
    logic [7:0] mem [64];
    bit         mem_init = 1'b0;
    int         rsp_cnt = 0;
    logic [5:0] rsp_addr = '0;
    int         stall_cnt = 0, seen_gen = 0, stall_seen = 0, stab_err = 0;
    bit         snap_ok = 1'b0;
    logic       snap_write = 1'b0;
    logic [5:0] snap_addr = '0;
    logic [7:0] snap_data = '0;
    int         n_tx = 0, n_txr = 0, n_txw = 0, wr_seq = 0, rd_seq = 0;
    logic [5:0] last_wr_addr = '0, last_rd_addr = '0;
    logic [7:0] last_wr_data = '0;
    int         n_rsp = 0;

    int n_checks = 0;
    int n_fail = 0;

    // Backing memory: decides ready on the falling edge, answers reads rsp_delay falling edges later.
    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] = 8'((i * 37) + 11);
            mem[5]   = 8'h3C;
            mem[13]  = 8'h77;
            mem_init = 1'b1;
        end
        if (seen_gen != stall_gen) begin
            stall_cnt = stall_cycles;
            seen_gen  = stall_gen;
            snap_ok   = 1'b0;
        end
        tx_rsp_valid = 1'b0;
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                tx_rsp_valid = 1'b1;
                tx_rsp_data  = mem[rsp_addr];
            end
        end
        tx_req_ready = 1'b0;
        if (tx_req_valid && rst) begin
            if (stall_cnt > 0) begin
                if (!snap_ok) begin
                    snap_write = tx_req_write;
                    snap_addr  = tx_req_addr;
                    snap_data  = tx_req_data;
                    snap_ok    = 1'b1;
                end else if (tx_req_write !== snap_write || tx_req_addr !== snap_addr ||
                             tx_req_data !== snap_data) begin
                    stab_err++;
                end
                if (rx_req_ready !== 1'b0) stab_err++;
                stall_cnt--;
                stall_seen++;
            end else begin
                tx_req_ready = 1'b1;
                n_tx++;
                if (tx_req_write) begin
                    mem[tx_req_addr] = tx_req_data;
                    n_txw++;
                    last_wr_addr = tx_req_addr;
                    last_wr_data = tx_req_data;
                    wr_seq = n_tx;
                end else begin
                    n_txr++;
                    last_rd_addr = tx_req_addr;
                    rd_seq   = n_tx;
                    rsp_addr = tx_req_addr;
                    rsp_cnt  = rsp_delay;
                end
            end
        end
    end

    always @(negedge clk) if (rx_rsp_valid) n_rsp++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request at a falling edge and return on the falling edge after it is accepted.
    task automatic issue(input logic w, input logic [5:0] a, input logic [7:0] d);
        int cnt;
        rx_req_valid = 1'b1;
        rx_req_write = w;
        rx_req_addr  = a;
        rx_req_data  = d;
        cnt = 0;
        while (!rx_req_ready && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        if (!rx_req_ready) check("accept_timeout", rx_req_ready, 1);
        @(negedge clk);
        rx_req_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [7:0] d, output int lat);
        lat = 1;
        while (!rx_rsp_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (!rx_rsp_valid) check("rsp_timeout", rx_rsp_valid, 1);
        d = rx_rsp_data;
    endtask

    task automatic rd(input logic [5:0] a, output logic [7:0] d, output int lat);
        issue(1'b0, a, 8'h00);
        get_rsp(d, lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [7:0] ref_mem [64];
        int lat, txr0, txw0, tx0, rsp0, st0, se0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_rx_req_ready", rx_req_ready, 0);
        check("rst_rx_rsp_valid", rx_rsp_valid, 0);
        check("rst_rx_rsp_data", rx_rsp_data, 0);
        check("rst_tx_req_valid", tx_req_valid, 0);
        check("rst_tx_req_write", tx_req_write, 0);
        check("rst_tx_req_addr", tx_req_addr, 0);
        check("rst_tx_req_data", tx_req_data, 0);
        rst = 1'b1;
        @(negedge clk);

        // Cold read miss, then a hit with no memory traffic
        txr0 = n_txr; txw0 = n_txw;
        issue(1'b0, 6'h05, 8'h00);
        check("miss_busy_ready", rx_req_ready, 0);
        get_rsp(d, lat);
        check("t1_rsp", d, 8'h3C);
        check("t1_txr", n_txr - txr0, 1);
        check("t1_txw", n_txw - txw0, 0);
        check("t1_rd_addr", last_rd_addr, 6'h05);
        tx0 = n_tx;
        rd(6'h05, d, lat);
        check("t1_hit_rsp", d, 8'h3C);
        check("t1_hit_lat", lat, 1);
        check("t1_hit_tx", n_tx - tx0, 0);

        // Write hit then read back
        txw0 = n_txw; txr0 = n_txr;
        issue(1'b1, 6'h05, 8'hA1);
        rd(6'h05, d, lat);
        check("t2_rsp", d, 8'hA1);
        check("t2_lat", lat, 1);
        check("t2_txw", n_txw - txw0, WT ? 1 : 0);
        check("t2_txr", n_txr - txr0, 0);

        // Conflict miss on index 5 evicts the written line
        issue(1'b1, 6'h05, 8'hA1);
        txw0 = n_txw; txr0 = n_txr;
        rd(6'h0D, d, lat);
        check("t3_rsp", d, 8'h77);
        check("t3_txw", n_txw - txw0, WT ? 0 : 1);
        check("t3_txr", n_txr - txr0, 1);
        check("t3_rd_addr", last_rd_addr, 6'h0D);
        check("t3_wr_addr", last_wr_addr, 6'h05);
        check("t3_wr_data", last_wr_data, 8'hA1);
        check("t3_wr_before_rd", wr_seq < rd_seq, 1);
        txr0 = n_txr;
        rd(6'h05, d, lat);
        check("t3_reread_rsp", d, 8'hA1);
        check("t3_reread_txr", n_txr - txr0, 1);

        // Memory stalls the outgoing write for 5 cycles
        st0 = stab_err; se0 = stall_seen;
        if (!WT) issue(1'b1, 6'h06, 8'h55);
        stall_cycles = 5;
        stall_gen++;
        @(negedge clk);
        if (WT) issue(1'b1, 6'h06, 8'h55);
        rd(6'h0E, d, lat);
        check("t4_rsp", d, 8'h11);
        check("t4_stall_cycles", stall_seen - se0, 5);
        check("t4_stable", stab_err - st0, 0);
        check("t4_wr_addr", last_wr_addr, 6'h06);
        check("t4_wr_data", last_wr_data, 8'h55);
        check("t4_mem06", mem[6], 8'h55);

        // Reset while waiting for fill data; the late response must be ignored
        rsp_delay = 10;
        txr0 = n_txr;
        issue(1'b0, 6'h15, 8'h00);
        lat = 0;
        while (n_txr == txr0 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check("t5_fill_issued", n_txr - txr0, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5_rst_tx_valid", tx_req_valid, 0);
        check("t5_rst_ready", rx_req_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        rsp0 = n_rsp;
        repeat (15) @(negedge clk);
        check("t5_stale_rsp", n_rsp - rsp0, 0);
        rsp_delay = 2;
        txr0 = n_txr;
        rd(6'h05, d, lat);
        check("t5_after_rst_txr", n_txr - txr0, 1);
        check("t5_after_rst_rsp", d, 8'hA1);

        // Random traffic against a reference image built from the current contents
        for (int i = 0; i < 64; i++) begin
            rd(6'(i), d, lat);
            ref_mem[i] = d;
        end
        for (int k = 0; k < 1000; k++) begin
            logic [5:0] a;
            logic [7:0] v;
            a = 6'($urandom_range(0, 63));
            v = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                issue(1'b1, a, v);
                ref_mem[a] = v;
            end else begin
                rd(a, d, lat);
                check("rand_rd", d, ref_mem[a]);
            end
        end
`ifdef CACHE_WRITE_THROUGH_EN
        repeat (4) @(negedge clk);
        for (int i = 0; i < 64; i++) check("wt_mem", mem[i], ref_mem[i]);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate cache with one data word per line.
- Sits between a requester (the testbench or a CPU) on the rx bus and a backing memory on the tx bus; both buses use the same memory-bus protocol.
- Reads that hit are answered from the cache. Misses evict the victim line (written back if dirty), fetch the missing word from memory, then complete the request.

Parameters:
- ADDR_WIDTH, 6, word address width.
- DATA_WIDTH, 8, data word width.
- INDEX_WIDTH, 3, line index bits; 2**INDEX_WIDTH lines; tag = ADDR_WIDTH-INDEX_WIDTH bits.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- rx_req_valid  in  1  requester request valid.
- rx_req_ready  out  1  cache can accept a request.
- rx_req_write  in  1  1=write, 0=read.
- rx_req_addr  in  ADDR_WIDTH  request address.
- rx_req_data  in  DATA_WIDTH  write data.
- rx_rsp_valid  out  1  read response strobe, one cycle.
- rx_rsp_data  out  DATA_WIDTH  read data.
- tx_req_valid  out  1  memory request valid.
- tx_req_ready  in  1  memory accepts request.
- tx_req_write  out  1  1=write, 0=read.
- tx_req_addr  out  ADDR_WIDTH  memory address.
- tx_req_data  out  DATA_WIDTH  write-back data.
- tx_rsp_valid  in  1  memory read data valid.
- tx_rsp_data  in  DATA_WIDTH  memory read data.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, port rst.
- Handshake: a request transfers on a cycle where valid && ready. Only reads produce a response; writes produce no response. tx_req_* are held stable while tx_req_valid is high and tx_req_ready is low.
- Reset (rst=0 at a clock edge):
  - All valid and dirty bits cleared; state goes to IDLE.
  - rx_req_ready=0, rx_rsp_valid=0, tx_req_valid=0.
  - rx_rsp_data, tx_req_addr, tx_req_data and tx_req_write reset to 0.
  - Reset mid-transaction abandons it; dirty data is lost.
- States:
  - IDLE: rx_req_ready=1. On an accepted request, latch op/addr/data and perform the lookup: hit = valid[index] && tag match.
  - IDLE, read hit: rx_rsp_valid=1 with line data in the next cycle; stay in IDLE.
  - IDLE, write hit: write the line and set dirty on the accept edge; stay in IDLE.
  - IDLE, miss with victim valid and dirty: go to WRITEBACK.
  - IDLE, miss otherwise: go to FILL_REQ.
  - WRITEBACK: tx_req_valid=1, write=1, address = {victim tag, index}, data = victim word. On tx_req_ready, go to FILL_REQ.
  - FILL_REQ: tx_req_valid=1, write=0, address = latched addr. On tx_req_ready, go to FILL_WAIT.
  - FILL_WAIT: wait for tx_rsp_valid, then install the line (valid=1, new tag).
    - Read: line data = tx_rsp_data, dirty=0; rx_rsp_valid=1 with that data the next cycle.
    - Write: line data = latched write data (overrides fetched word), dirty=1.
    - Return to IDLE.
- rx_req_ready is 0 in every non-IDLE state, so only one miss is outstanding at a time.
- Hit latency: read response 1 cycle after accept; back-to-back hits are accepted every cycle.
- Miss latency: bounded only by memory ready/response timing.
- A tx_rsp_valid arriving outside FILL_WAIT is ignored.
- No overflow or wrap concerns: the address space is fully covered, and the line index is the address LSBs.

Optional Feature:
- Macro CACHE_WRITE_THROUGH_EN.
- Defined: write-through, no-write-allocate.
  - Every accepted write is forwarded as a tx write request; the cache stays in a WRITE_FWD state until tx_req_ready.
  - On a write hit the line is also updated.
  - A write miss does not allocate.
  - Dirty bits are never set; the WRITEBACK state is unreachable.
- Undefined: the write-back, write-allocate behaviour above.

Test Plan:
- Reset then read 0x05 (memory[0x05]=0x3C) -> one tx read to 0x05, no writeback; rx_rsp_data=0x3C. A second read of 0x05 -> rsp 1 cycle after accept, no tx activity.
- Write 0x05=0xA1, then read 0x05 -> rsp 0xA1; no tx write issued.
- Write 0x05=0xA1, then read 0x0D (same index, memory[0x0D]=0x77) -> tx write 0x05/0xA1, then tx read 0x0D; rsp 0x77. Read 0x05 again -> tx read, rsp 0xA1.
- Memory holding tx_req_ready low for 5 cycles during WRITEBACK -> tx_req_* stable and rx_req_ready=0 throughout; completes correctly afterwards.
- Assert rst=0 mid-FILL_WAIT -> next cycle tx_req_valid=0 and rx_req_ready=0. After release, read 0x05 -> miss (valid bits cleared) and fetch from memory.
- Randomised 1000 reads/writes across all 64 addresses against a reference array -> every read response matches; with CACHE_WRITE_THROUGH_EN, memory always equals the reference.
